// File: rtl/cdc_pulse_chan_arbiter.sv
// ============================================================================
// Module  : cdc_pulse_chan_arbiter
// Brief   : Round-robin arbiter sharing one four-phase req/ack CDC channel
//           among single-cycle pulse requesters in the src_clk domain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdc_pulse_chan_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               src_clk,
    input  logic               src_rst_n,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic [NUM_REQ-1:0] req_drop,
    output logic [NUM_REQ-1:0] req_done,
    output logic               chan_req,
    output logic [ID_W-1:0]    chan_id,
    input  logic               chan_ack_async,
    output logic               busy,
    output logic               timeout_flag,
    input  logic               timeout_clr
);

    localparam int                 c_CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]    c_LAST_ID    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_ack_meta;
    logic                 r_ack_s;
    logic [NUM_REQ-1:0]   r_pending;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [c_CNT_W-1:0]   r_phase_cnt;
    logic                 r_chan_req;
    logic [ID_W-1:0]      r_chan_id;
    logic [NUM_REQ-1:0]   r_req_drop;
    logic [NUM_REQ-1:0]   r_req_done;
    logic                 r_busy;
    logic                 r_timeout_flag;

    logic                 w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic [ID_W-1:0]      w_hi_id;
    logic [ID_W-1:0]      w_lo_id;
    logic                 w_hi_hit;
    logic [NUM_REQ-1:0]   w_win;
    logic [NUM_REQ-1:0]   w_pending_nxt;
    logic [NUM_REQ-1:0]   w_drop_nxt;
    logic [NUM_REQ-1:0]   w_done_nxt;
    logic                 w_leave;
    logic                 w_tmo_hit;

    // Descending scan: the last hit recorded is the lowest index, first from
    // rr_ptr upward, falling back to the lowest overall for the wrap case.
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi_id  = '0;
        w_lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lo_id = ID_W'(i);
                if (ID_W'(i) >= r_rr_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_id  = ID_W'(i);
                end
            end
        end
        w_grant_id = w_hi_hit ? w_hi_id : w_lo_id;
        w_grant    = (r_state == ST_IDLE) && (|r_pending);
    end

    always_comb begin
        w_win         = '0;
        w_pending_nxt = '0;
        w_drop_nxt    = '0;
        w_done_nxt    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win[i]         = w_grant && (w_grant_id == ID_W'(i));
            w_pending_nxt[i] = w_win[i] ? req_pulse[i] : (r_pending[i] | req_pulse[i]);
            w_drop_nxt[i]    = req_pulse[i] & r_pending[i] & ~w_win[i];
            w_done_nxt[i]    = (r_state == ST_REL) && !r_ack_s && (r_chan_id == ID_W'(i));
        end
    end

    assign w_leave   = ((r_state == ST_REQ) &&  r_ack_s) ||
                       ((r_state == ST_REL) && !r_ack_s);
    assign w_tmo_hit = (r_state != ST_IDLE) && !w_leave && (r_phase_cnt == c_TIMEOUT_M1);

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            r_state        <= ST_IDLE;
            r_ack_meta     <= 1'b0;
            r_ack_s        <= 1'b0;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_phase_cnt    <= '0;
            r_chan_req     <= 1'b0;
            r_chan_id      <= '0;
            r_req_drop     <= '0;
            r_req_done     <= '0;
            r_busy         <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_ack_meta <= chan_ack_async;
            r_ack_s    <= r_ack_meta;
            r_pending  <= w_pending_nxt;
            r_req_drop <= w_drop_nxt;
            r_req_done <= w_done_nxt;

            if (w_tmo_hit) begin
                r_timeout_flag <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout_flag <= 1'b0;
            end

            // The handshake is never abandoned on timeout; order must hold.
            case (r_state)
                ST_IDLE: begin
                    r_phase_cnt <= '0;
                    if (w_grant) begin
                        r_chan_req <= 1'b1;
                        r_chan_id  <= w_grant_id;
                        r_rr_ptr   <= (w_grant_id == c_LAST_ID) ? '0 : w_grant_id + 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (r_ack_s) begin
                        r_chan_req  <= 1'b0;
                        r_phase_cnt <= '0;
                        r_state     <= ST_REL;
                    end else if (r_phase_cnt != c_TIMEOUT) begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                ST_REL: begin
                    if (!r_ack_s) begin
                        r_busy      <= 1'b0;
                        r_phase_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else if (r_phase_cnt != c_TIMEOUT) begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                default: begin
                    r_chan_req  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_phase_cnt <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign chan_req     = r_chan_req;
    assign chan_id      = r_chan_id;
    assign req_drop     = r_req_drop;
    assign req_done     = r_req_done;
    assign busy         = r_busy;
    assign timeout_flag = r_timeout_flag;

endmodule

`default_nettype wire

// File: tb/tb_cdc_pulse_chan_arbiter.sv
// ============================================================================
// Module  : tb_cdc_pulse_chan_arbiter
// Brief   : Directed vector table plus hand sequences for the CDC channel arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cdc_pulse_chan_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic [3:0] req_drop;
    logic [3:0] req_done;
    logic       chan_req;
    logic [1:0] chan_id;
    logic       chan_ack_async;
    logic       busy;
    logic       timeout_flag;
    logic       timeout_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cdc_pulse_chan_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2),
        .TIMEOUT (8)
    ) dut (
        .src_clk        (clk),
        .src_rst_n      (rst_n),
        .req_pulse      (req_pulse),
        .req_drop       (req_drop),
        .req_done       (req_done),
        .chan_req       (chan_req),
        .chan_id        (chan_id),
        .chan_ack_async (chan_ack_async),
        .busy           (busy),
        .timeout_flag   (timeout_flag),
        .timeout_clr    (timeout_clr)
    );

    typedef struct {
        logic [3:0] pulse;
        logic       ack;
        logic       clr;
        logic       req;
        logic [1:0] id;
        logic       bsy;
        logic [3:0] done;
        logic [3:0] drop;
        logic       tf;
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the destination: acks after chan_req is seen, then releases.
    task automatic do_handshake(input int id);
        for (int k = 0; k < 40 && chan_req !== 1'b1; k++) tick();
        check($sformatf("hs%0d_req_up", id), 32'(chan_req), 32'd1);
        check($sformatf("hs%0d_id", id), 32'(chan_id), 32'(id));
        check($sformatf("hs%0d_busy", id), 32'(busy), 32'd1);
        @(negedge clk) chan_ack_async = 1'b1;
        for (int k = 0; k < 40 && chan_req !== 1'b0; k++) tick();
        check($sformatf("hs%0d_req_down", id), 32'(chan_req), 32'd0);
        @(negedge clk) chan_ack_async = 1'b0;
        for (int k = 0; k < 40 && req_done === 4'b0000; k++) tick();
        check($sformatf("hs%0d_done", id), 32'(req_done), 32'd1 << id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_high;
        int n_done;

        // pulse ack clr | req id busy done drop tf
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0100, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[19] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[20] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[21] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[22] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        tbl[23] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0};
        tbl[24] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0};

        rst_n          = 1'b0;
        req_pulse      = 4'b0000;
        chan_ack_async = 1'b0;
        timeout_clr    = 1'b0;
        repeat (3) tick();
        check("rst_chan_req", 32'(chan_req), 32'd0);
        check("rst_chan_id", 32'(chan_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_req_drop", 32'(req_drop), 32'd0);
        check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single request on ID 2, then a grant collision on ID 0.
        for (int v = 0; v < 25; v++) begin
            @(negedge clk);
            req_pulse      = tbl[v].pulse;
            chan_ack_async = tbl[v].ack;
            timeout_clr    = tbl[v].clr;
            tick();
            check($sformatf("vec%0d", v),
                  32'({chan_req, chan_id, busy, req_done, req_drop, timeout_flag}),
                  32'({tbl[v].req, tbl[v].id, tbl[v].bsy, tbl[v].done, tbl[v].drop, tbl[v].tf}));
        end

        // Fairness from rr_ptr=0, then wrap back to 0.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) req_pulse = 4'b1111;
        @(negedge clk) req_pulse = 4'b0000;
        do_handshake(0);
        do_handshake(1);
        do_handshake(2);
        do_handshake(3);
        @(negedge clk) req_pulse = 4'b1001;
        @(negedge clk) req_pulse = 4'b0000;
        do_handshake(0);
        do_handshake(3);

        // Extra pulses on ID 1 while pending and channel busy with ID 0.
        @(negedge clk) req_pulse = 4'b0001;
        tick();
        @(negedge clk) req_pulse = 4'b0010;
        tick();
        check("drop_first_accepted", 32'(req_drop), 32'd0);
        check("drop_grant0_id", 32'({chan_req, chan_id}), 32'({1'b1, 2'd0}));
        @(negedge clk) req_pulse = 4'b0010;
        tick();
        check("drop_pulse_a", 32'(req_drop), 32'b0010);
        @(negedge clk) req_pulse = 4'b0000;
        tick();
        check("drop_gap", 32'(req_drop), 32'd0);
        @(negedge clk) req_pulse = 4'b0010;
        tick();
        check("drop_pulse_b", 32'(req_drop), 32'b0010);
        @(negedge clk) req_pulse = 4'b0000;
        do_handshake(0);
        do_handshake(1);
        n_high = 0;
        repeat (12) begin
            tick();
            if (chan_req === 1'b1) n_high++;
        end
        check("drop_single_grant", 32'(n_high), 32'd0);
        check("no_spurious_timeout", 32'(timeout_flag), 32'd0);

        // Timeout with ack held low; clear held through the hit so set wins.
        @(negedge clk) begin
            timeout_clr = 1'b1;
            req_pulse   = 4'b0100;
        end
        @(negedge clk) req_pulse = 4'b0000;
        for (int k = 0; k < 40 && chan_req !== 1'b1; k++) tick();
        check("tmo_req_up", 32'(chan_req), 32'd1);
        repeat (7) tick();
        check("tmo_before", 32'(timeout_flag), 32'd0);
        tick();
        check("tmo_set_wins", 32'({timeout_flag, chan_req}), 32'b11);
        @(negedge clk) timeout_clr = 1'b0;
        repeat (4) tick();
        check("tmo_sticky_waiting", 32'({timeout_flag, chan_req, busy}), 32'b111);
        do_handshake(2);
        check("tmo_sticky_after", 32'(timeout_flag), 32'd1);
        @(negedge clk) timeout_clr = 1'b1;
        @(negedge clk) timeout_clr = 1'b0;
        check("tmo_cleared", 32'(timeout_flag), 32'd0);

        // Reset in the middle of a REQ phase with another request pending.
        @(negedge clk) req_pulse = 4'b1000;
        @(negedge clk) req_pulse = 4'b0000;
        for (int k = 0; k < 40 && chan_req !== 1'b1; k++) tick();
        check("mid_rst_req_id", 32'({chan_req, chan_id}), 32'({1'b1, 2'd3}));
        @(negedge clk) req_pulse = 4'b0001;
        @(negedge clk) req_pulse = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_async", 32'({chan_req, busy, chan_id}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        n_high = 0;
        n_done = 0;
        repeat (15) begin
            tick();
            if (chan_req === 1'b1) n_high++;
            if (req_done !== 4'b0000) n_done++;
        end
        check("post_rst_no_req", 32'(n_high), 32'd0);
        check("post_rst_no_done", 32'(n_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
